// File: rtl/cascade_down_counter.sv
// cascade_down_counter
// A chain of modulo down-counters advanced by a tick strobe. Each stage counts
// START_i..0 and wraps back to START_i. The wrap raises a one-cycle carry, and
// the same tick then advances the next stage on that clock edge. With
// EDGE_DETECT=1, a slow asynchronous level is synchronised first, and each of
// its rising edges counts once.
module cascade_down_counter #(
   parameter int                      WIDTH       = 4,
   parameter int                      STAGES      = 2,
   parameter logic [WIDTH*STAGES-1:0] START_VEC   = {4'd9, 4'd2},
   parameter bit                      EDGE_DETECT = 1'b0
) (
   input  logic                      i_clock,
   input  logic                      i_resetn,
   input  logic                      i_enable,
   input  logic                      i_clr,
   input  logic                      i_tick_in,
   output logic [WIDTH*STAGES-1:0]   o_value,
   output logic [STAGES-1:0]         o_carry,
   output logic                      o_done
);

   // Elaboration-time sanity checks on the shape of the chain.
   if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("cascade_down_counter: STAGES must be in 1..8");
   end
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("cascade_down_counter: WIDTH must be in 1..32");
   end

   logic              w_strobe;
   logic [STAGES-1:0] w_zero;
   logic [STAGES-1:0] w_adv;

   // Tick front end: either a plain gated strobe, or synchroniser + rising-edge detector.
   if (EDGE_DETECT) begin : g_edge
      logic r_s1;
      logic r_s2;
      logic r_s3;

      // Two-flop synchroniser followed by a history flop for edge detection.
      always_ff @(posedge i_clock or negedge i_resetn) begin
         if (!i_resetn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
         end else begin
            r_s1 <= i_tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
         end
      end

      // The enable gates the detected edge, so edges seen while disabled are dropped.
      assign w_strobe = r_s2 & ~r_s3 & i_enable;
   end else begin : g_level
      assign w_strobe = i_tick_in & i_enable;
   end

   // One counter per stage. A stage advances only when every lower stage sits at zero,
   // so a single strobe can ripple through the whole chain in one cycle.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] START_I = START_VEC[gi*WIDTH +: WIDTH];

      if (64'(START_I) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_start
         $error("cascade_down_counter: stage reload value exceeds WIDTH range");
      end

      logic [WIDTH-1:0] r_value;
      logic             r_carry;

      assign w_zero[gi] = (r_value == '0);

      if (gi == 0) begin : g_adv_first
         assign w_adv[gi] = w_strobe;
      end else begin : g_adv_chain
         assign w_adv[gi] = w_strobe & (&w_zero[gi-1:0]);
      end

      // Stage update: clear beats advance; wrap reloads and pulses carry.
      always_ff @(posedge i_clock or negedge i_resetn) begin
         if (!i_resetn) begin
            r_value <= START_I;
            r_carry <= 1'b0;
         end else if (i_clr) begin
            r_value <= START_I;
            r_carry <= 1'b0;
         end else if (w_adv[gi]) begin
            if (w_zero[gi]) begin
               r_value <= START_I;
               r_carry <= 1'b1;
            end else begin
               r_value <= r_value - 1'b1;
               r_carry <= 1'b0;
            end
         end else begin
            r_carry <= 1'b0;
         end
      end

      assign o_value[gi*WIDTH +: WIDTH] = r_value;
      assign o_carry[gi]                = r_carry;
   end

   assign o_done = o_carry[STAGES-1];

endmodule

// File: tb/tb_cascade_down_counter.sv
// Bench for cascade_down_counter. Three instances share one stimulus stream:
//   A: default parameters, strobe front end
//   B: default parameters, edge-detect front end
//   C: WIDTH=3, STAGES=3, START={0,7,4}, strobe front end
// The reference treats each chain as a mixed-radix tick total: it keeps a count
// of accepted ticks modulo the product of (START_i+1), then derives each digit
// and each carry from that count by arithmetic.
module tb_cascade_down_counter;

   logic clock = 1'b0;
   logic resetn;
   logic enable;
   logic clr;
   logic tick_in;

   logic [7:0] o_value_a;
   logic [1:0] o_carry_a;
   logic       o_done_a;
   logic [7:0] o_value_b;
   logic [1:0] o_carry_b;
   logic       o_done_b;
   logic [8:0] o_value_c;
   logic [2:0] o_carry_c;
   logic       o_done_c;

   int errors = 0;
   int checks = 0;
   bit cmp_on = 1'b0;

   always #5 clock = ~clock;

   cascade_down_counter #(.WIDTH(4), .STAGES(2), .START_VEC({4'd9, 4'd2}), .EDGE_DETECT(1'b0)) u_a (
      .i_clock(clock), .i_resetn(resetn), .i_enable(enable), .i_clr(clr), .i_tick_in(tick_in),
      .o_value(o_value_a), .o_carry(o_carry_a), .o_done(o_done_a));

   cascade_down_counter #(.WIDTH(4), .STAGES(2), .START_VEC({4'd9, 4'd2}), .EDGE_DETECT(1'b1)) u_b (
      .i_clock(clock), .i_resetn(resetn), .i_enable(enable), .i_clr(clr), .i_tick_in(tick_in),
      .o_value(o_value_b), .o_carry(o_carry_b), .o_done(o_done_b));

   cascade_down_counter #(.WIDTH(3), .STAGES(3), .START_VEC({3'd0, 3'd7, 3'd4}), .EDGE_DETECT(1'b0)) u_c (
      .i_clock(clock), .i_resetn(resetn), .i_enable(enable), .i_clr(clr), .i_tick_in(tick_in),
      .o_value(o_value_c), .o_carry(o_carry_c), .o_done(o_done_c));

   // ---------------- reference ----------------
   int st_a[8] = '{2, 9, 0, 0, 0, 0, 0, 0};
   int st_c[8] = '{4, 7, 0, 0, 0, 0, 0, 0};
   localparam int P_A = 30;   // (2+1)*(9+1)
   localparam int P_C = 40;   // (4+1)*(7+1)*(0+1)

   int         n_a;
   int         n_b;
   int         n_c;
   logic [7:0] c_a;
   logic [7:0] c_b;
   logic [7:0] c_c;
   logic [2:0] hist;          // tick_in seen at the previous 1, 2, 3 edges

   wire stb_ac = tick_in & enable;
   wire stb_b  = hist[1] & ~hist[2] & enable;

   function automatic logic [31:0] mdl_value(input int n, input int w, input int s, input int st[8]);
      logic [31:0] v;
      int rem;
      int d;
      v   = '0;
      rem = n;
      for (int i = 0; i < s; i++) begin
         d   = rem % (st[i] + 1);
         rem = rem / (st[i] + 1);
         v   = v | (32'(st[i] - d) << (i * w));
      end
      return v;
   endfunction

   // Carry of stage i fires when the new total is a multiple of the product of radices 0..i.
   function automatic logic [7:0] mdl_carry(input int n, input int s, input int st[8]);
      logic [7:0] c;
      int m;
      c = '0;
      m = 1;
      for (int i = 0; i < s; i++) begin
         m    = m * (st[i] + 1);
         c[i] = (((n + 1) % m) == 0);
      end
      return c;
   endfunction

   function automatic int nxt(input int n, input logic stb, input logic c, input int p);
      if (c) return 0;
      if (stb) return (n + 1) % p;
      return n;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         n_a  <= 0;
         n_b  <= 0;
         n_c  <= 0;
         c_a  <= '0;
         c_b  <= '0;
         c_c  <= '0;
         hist <= '0;
      end else begin
         hist <= {hist[1:0], tick_in};
         n_a  <= nxt(n_a, stb_ac, clr, P_A);
         n_b  <= nxt(n_b, stb_b, clr, P_A);
         n_c  <= nxt(n_c, stb_ac, clr, P_C);
         c_a  <= (stb_ac && !clr) ? mdl_carry(n_a, 2, st_a) : 8'h00;
         c_b  <= (stb_b && !clr) ? mdl_carry(n_b, 2, st_a) : 8'h00;
         c_c  <= (stb_ac && !clr) ? mdl_carry(n_c, 3, st_c) : 8'h00;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all three instances against the reference.
   always @(negedge clock) begin
      if (cmp_on) begin
         chk("a_value", 32'(o_value_a), mdl_value(n_a, 4, 2, st_a));
         chk("a_carry", 32'(o_carry_a), 32'(c_a[1:0]));
         chk("a_done",  32'(o_done_a),  32'(c_a[1]));
         chk("b_value", 32'(o_value_b), mdl_value(n_b, 4, 2, st_a));
         chk("b_carry", 32'(o_carry_b), 32'(c_b[1:0]));
         chk("b_done",  32'(o_done_b),  32'(c_b[1]));
         chk("c_value", 32'(o_value_c), mdl_value(n_c, 3, 3, st_c));
         chk("c_carry", 32'(o_carry_c), 32'(c_c[2:0]));
         chk("c_done",  32'(o_done_c),  32'(c_c[2]));
      end
   end

   // ---------------- directed stimulus ----------------
   logic [7:0] seq_v[6] = '{8'h91, 8'h90, 8'h82, 8'h81, 8'h80, 8'h72};
   logic [1:0] seq_c[6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};

   task automatic step(input logic t, input logic e, input logic c);
      tick_in = t;
      enable  = e;
      clr     = c;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      resetn = 1'b1;
   endtask

   initial begin
      resetn  = 1'b0;
      enable  = 1'b0;
      clr     = 1'b0;
      tick_in = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      // reset values while held in reset
      chk("rst_value", 32'(o_value_a), 32'h92);
      chk("rst_carry", 32'(o_carry_a), 32'h0);
      chk("rst_done",  32'(o_done_a),  32'h0);
      chk("rst_value_c", 32'(o_value_c), 32'h03C);
      cmp_on = 1'b1;
      resetn = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      chk("rel_value", 32'(o_value_a), 32'h92);
      chk("rel_done",  32'(o_done_a),  32'h0);

      // stage 0 sequence with one strobe every three cycles
      do_reset();
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b1, 1'b0);
         chk("seq_value", 32'(o_value_a), 32'(seq_v[k]));
         chk("seq_carry", 32'(o_carry_a), 32'(seq_c[k]));
         step(1'b0, 1'b1, 1'b0);
         chk("seq_carry_drop", 32'(o_carry_a), 32'h0);
         step(1'b0, 1'b1, 1'b0);
      end

      // full cascade: 30 consecutive strobes
      do_reset();
      repeat (29) step(1'b1, 1'b1, 1'b0);
      chk("casc_29_value", 32'(o_value_a), 32'h00);
      chk("casc_29_done",  32'(o_done_a),  32'h0);
      step(1'b1, 1'b1, 1'b0);
      chk("casc_30_value", 32'(o_value_a), 32'h92);
      chk("casc_30_carry", 32'(o_carry_a), 32'h3);
      chk("casc_30_done",  32'(o_done_a),  32'h1);
      step(1'b0, 1'b1, 1'b0);
      chk("casc_done_drop", 32'(o_done_a), 32'h0);

      // clr beats a simultaneous strobe
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      chk("pre_clr_value", 32'(o_value_a), 32'h91);
      step(1'b1, 1'b1, 1'b1);
      chk("clr_value", 32'(o_value_a), 32'h92);
      chk("clr_carry", 32'(o_carry_a), 32'h0);

      // strobes with enable low are discarded
      step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("gate_value", 32'(o_value_a), 32'h91);
      step(1'b0, 1'b1, 1'b0);

      // edge-detect front end: high 10, low 5, high 1
      do_reset();
      repeat (3) step(1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b1, 1'b0);
         if (k <= 2) chk("ed_wait", 32'(o_value_b), 32'h92);
         else        chk("ed_first", 32'(o_value_b), 32'h91);
      end
      repeat (5) step(1'b0, 1'b1, 1'b0);
      chk("ed_low", 32'(o_value_b), 32'h91);
      step(1'b1, 1'b1, 1'b0);
      chk("ed_pulse_e0", 32'(o_value_b), 32'h91);
      step(1'b0, 1'b1, 1'b0);
      chk("ed_pulse_e1", 32'(o_value_b), 32'h91);
      step(1'b0, 1'b1, 1'b0);
      chk("ed_pulse_e2", 32'(o_value_b), 32'h90);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      chk("ed_final", 32'(o_value_b), 32'h90);

      // asynchronous reset in the middle of a count
      do_reset();
      repeat (14) step(1'b1, 1'b1, 1'b0);
      tick_in = 1'b0;
      chk("mid_value", 32'(o_value_a), 32'h50);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_value", 32'(o_value_a), 32'h92);
      chk("async_carry", 32'(o_carry_a), 32'h0);
      chk("async_done",  32'(o_done_a),  32'h0);
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // parameter sweep instance: pass-through top stage
      do_reset();
      repeat (5) step(1'b1, 1'b1, 1'b0);
      chk("sweep5_value", 32'(o_value_c), 32'h034);
      chk("sweep5_carry", 32'(o_carry_c), 32'h1);
      repeat (34) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("sweep40_value", 32'(o_value_c), 32'h03C);
      chk("sweep40_carry", 32'(o_carry_c), 32'h7);
      chk("sweep40_done",  32'(o_done_c),  32'h1);
      repeat (4) step(1'b0, 1'b1, 1'b0);

      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cascade_down_counter.md
# cascade_down_counter

Parametrised chain of modulo down-counters driven by a tick input, used wherever the game needs a divided time base or a multi-digit countdown, such as a frame-tick to second-tick divider or a lives/timer display. Each stage counts START..0 and then wraps to START. On the wrap it emits a one-cycle carry that advances the next stage. The block is fully synchronous to one system clock: ticks are strobes or levels, never clocks, and an optional edge-detect front end accepts slow asynchronous pulse sources.

## Interface
- WIDTH, 4: bits per stage value.
- STAGES, 2: number of cascaded stages (1..8).
- START_VEC, {4'd9, 4'd2}: packed per-stage reload values, WIDTH*STAGES bits; stage i uses bits [i*WIDTH +: WIDTH]. Stage 0 is the least significant slice.
- EDGE_DETECT, 0: 0 means tick_in is a one-cycle synchronous strobe; 1 means tick_in is an asynchronous level, with each rising edge counted once.
- clock  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- enable  input  1  ticks are counted only while high.
- clr  input  1  synchronous clear: reload all stages and drop carries.
- tick_in  input  1  count request (interpretation set by EDGE_DETECT).
- value  output  WIDTH*STAGES  current stage values, registered, packed as START_VEC.
- carry  output  STAGES  per-stage registered wrap pulse.
- done  output  1  equals carry[STAGES-1].

## Operation
- **Internal tick (strobe):**
  - EDGE_DETECT=0: strobe = tick_in & enable.
  - EDGE_DETECT=1: tick_in passes through two synchroniser flops (s1, s2) and a history flop s3; strobe = s2 & ~s3 & enable.
- **Stage advance condition:** adv[0] = strobe; adv[i] = adv[i-1] & (value_i-1 == 0). The ripple is combinational within one cycle, so all affected stages update on the same edge.
- **Per-stage update on each edge (highest priority first):**
  - clr: value_i ← START_i, carry_i ← 0.
  - adv[i] and value_i == 0: value_i ← START_i, carry_i ← 1.
  - adv[i] and value_i != 0: value_i ← value_i − 1, carry_i ← 0.
  - otherwise: value hold, carry_i ← 0.
- **Carry timing:** carry is a single-cycle pulse, never held. Back-to-back wraps on consecutive strobes give carry high on consecutive cycles.
- **START_i = 0:** the stage stays at 0 and carries on every advance; it behaves as a pass-through.
- **Range:** values are always within [0, START_i]. START_i must be ≤ 2^WIDTH−1; this is checked by an elaboration-time assertion.
- **Sequence per stage:** START_i, START_i−1, …, 0, START_i, … For the default stage 0 this is 2, 1, 0, 2.
- **enable low:** strobes are discarded, not queued. With EDGE_DETECT=1 the synchroniser keeps running, so an edge that arrives while disabled is lost.
- **clr and strobe in the same cycle:** clr wins and the tick is lost.

## Timing
- **Reset values:**
  - value_i = START_i.
  - carry = 0, done = 0.
  - s1 = s2 = s3 = 0.
  - Reset takes effect immediately on resetn falling, regardless of clock.
- **Reset release:** first counting edge is the first rising clock edge with resetn high.
- **EDGE_DETECT=0:** tick_in high at edge E → value and carry change at E (visible the next cycle). Latency is 1 cycle.
- **EDGE_DETECT=1:**
  - tick_in sampled high at edge E0 → s2 high after E1 → value and carry update at E2.
  - A level held high for N cycles counts once.
  - Pulses shorter than one clock period may be missed.
- **Reset mid-operation:** all counts and pending synchroniser state are discarded; no carry is emitted on reset.
- **Full-chain wrap:** when every stage is 0 and a strobe arrives, all stages reload on the same edge and all carries (and done) pulse together for one cycle.

## Test plan
- **Reset values:** reset with defaults → value = {4'd9, 4'd2}, carry = 2'b00, done = 0 while resetn low and on the first cycle after release.
- **Stage 0 sequence:** EDGE_DETECT=0, enable=1, one strobe every 3 cycles → stage 0 reads 2, 1, 0, 2, 1, 0. carry[0] pulses exactly one cycle on each 0→2 wrap, and stage 1 decrements 9→8→7 at those same edges.
- **Full cascade:** 30 consecutive strobes from reset → on the 30th strobe value returns to {9, 2}, carry = 2'b11 and done = 1 for exactly one cycle. done = 0 on all other cycles.
- **Priority and gating:**
  - clr asserted together with a strobe while stage 0 = 1 → value = {9, 2}, carry = 0.
  - Strobes applied with enable=0 → value unchanged.
- **Edge-detect front end:** EDGE_DETECT=1, tick_in held high for 10 cycles, then low 5, then high 1 → exactly two decrements (2→1→0). Each decrement occurs at the second edge after tick_in is first sampled high.
- **Reset mid-count:**
  - Assert resetn low asynchronously between edges while value = {5, 0} → value = {9, 2} immediately, with no carry pulse.
  - Parameter sweep: WIDTH=3, STAGES=3, START_VEC={3'd0, 3'd7, 3'd4}. Stage 2 (START=0) must carry on every stage-1 wrap.
